// File: rtl/mul_add_r2.sv
// rtl/mul_add_r2.sv - sequential radix-2 shift-add multiply-accumulate, res = op1 * op2 + add
// Retires one multiplier bit per clock; used to rebuild dividends from divider results.
module mul_add_r2 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   op1_i,
  input  logic [WIDTH-1:0]   op2_i,
  input  logic [WIDTH-1:0]   add_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] res_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;

  // hi stays below 2^WIDTH between steps, so the WIDTH+1 bit sum never overflows
  assign sum     = hi_q + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign shifted = {sum, lo_q} >> 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = CALC;
          cnt_d   = '0;
          mcand_d = op1_i;
          hi_d    = {1'b0, add_i};
          lo_d    = op2_i;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        hi_d = shifted[2*WIDTH:WIDTH];
        lo_d = shifted[WIDTH-1:0];
        if (cnt_q == LAST) begin
          state_d = DONE;
          res_d   = shifted[2*WIDTH-1:0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end

  assign busy_o = (state_q == CALC);
  assign done_o = (state_q == DONE);
  assign res_o  = res_q;

endmodule
